// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared types and constants for the JTAG TAP controller: TAP state encoding,
// decoded-instruction enum and the Capture-IR pattern.
package jtag_tap_ctrl_pkg;

  // IEEE 1149.1 recommended 4-bit state encoding.
  typedef logic [3:0] ty_STATE_TAP_FSM;

  localparam ty_STATE_TAP_FSM ST_TEST_LOGIC_RESET = 4'hF;
  localparam ty_STATE_TAP_FSM ST_RUN_TEST_IDLE    = 4'hC;
  localparam ty_STATE_TAP_FSM ST_SELECT_DR        = 4'h7;
  localparam ty_STATE_TAP_FSM ST_CAPTURE_DR       = 4'h6;
  localparam ty_STATE_TAP_FSM ST_SHIFT_DR         = 4'h2;
  localparam ty_STATE_TAP_FSM ST_EXIT1_DR         = 4'h1;
  localparam ty_STATE_TAP_FSM ST_PAUSE_DR         = 4'h3;
  localparam ty_STATE_TAP_FSM ST_EXIT2_DR         = 4'h0;
  localparam ty_STATE_TAP_FSM ST_UPDATE_DR        = 4'h5;
  localparam ty_STATE_TAP_FSM ST_SELECT_IR        = 4'h4;
  localparam ty_STATE_TAP_FSM ST_CAPTURE_IR       = 4'hE;
  localparam ty_STATE_TAP_FSM ST_SHIFT_IR         = 4'hA;
  localparam ty_STATE_TAP_FSM ST_EXIT1_IR         = 4'h9;
  localparam ty_STATE_TAP_FSM ST_PAUSE_IR         = 4'hB;
  localparam ty_STATE_TAP_FSM ST_EXIT2_IR         = 4'h8;
  localparam ty_STATE_TAP_FSM ST_UPDATE_IR        = 4'hD;

  localparam int IR_OP_IDCODE = 1;
  localparam int IDCODE_W     = 32;

  typedef enum logic [1:0] {
    INSTR_BYPASS,
    INSTR_IDCODE,
    INSTR_USER
  } ty_INSTR;

  // Capture-IR loads ...01 so a board-level scan can locate IR boundaries.
  function automatic logic [31:0] ir_capture_pattern(input int width);
    return (width >= 2) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_fsm_sync.sv
// 16-state IEEE 1149.1 TAP state machine, synchronous active-high reset,
// with decoded capture/shift/update flags for the datapath.
module jtag_tap_fsm_sync
  import jtag_tap_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            tms,
  output ty_STATE_TAP_FSM state,
  output logic            is_reset,
  output logic            is_capture_dr,
  output logic            is_shift_dr,
  output logic            is_update_dr,
  output logic            is_capture_ir,
  output logic            is_shift_ir,
  output logic            is_update_ir
);

  ty_STATE_TAP_FSM state_nxt;

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = ST_TEST_LOGIC_RESET;
    case (state)
      ST_TEST_LOGIC_RESET: state_nxt = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
      ST_RUN_TEST_IDLE:    state_nxt = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_DR:        state_nxt = tms ? ST_SELECT_IR        : ST_CAPTURE_DR;
      ST_CAPTURE_DR:       state_nxt = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_SHIFT_DR:         state_nxt = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_EXIT1_DR:         state_nxt = tms ? ST_UPDATE_DR        : ST_PAUSE_DR;
      ST_PAUSE_DR:         state_nxt = tms ? ST_EXIT2_DR         : ST_PAUSE_DR;
      ST_EXIT2_DR:         state_nxt = tms ? ST_UPDATE_DR        : ST_SHIFT_DR;
      ST_UPDATE_DR:        state_nxt = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_IR:        state_nxt = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR:       state_nxt = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_SHIFT_IR:         state_nxt = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_EXIT1_IR:         state_nxt = tms ? ST_UPDATE_IR        : ST_PAUSE_IR;
      ST_PAUSE_IR:         state_nxt = tms ? ST_EXIT2_IR         : ST_PAUSE_IR;
      ST_EXIT2_IR:         state_nxt = tms ? ST_UPDATE_IR        : ST_SHIFT_IR;
      ST_UPDATE_IR:        state_nxt = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      default:             state_nxt = ST_TEST_LOGIC_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_TEST_LOGIC_RESET;
    else     state <= state_nxt;
  end

  assign is_reset      = (state == ST_TEST_LOGIC_RESET);
  assign is_capture_dr = (state == ST_CAPTURE_DR);
  assign is_shift_dr   = (state == ST_SHIFT_DR);
  assign is_update_dr  = (state == ST_UPDATE_DR);
  assign is_capture_ir = (state == ST_CAPTURE_IR);
  assign is_shift_ir   = (state == ST_SHIFT_IR);
  assign is_update_ir  = (state == ST_UPDATE_IR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: instruction register, BYPASS/IDCODE/USER data
// registers, TDO mux and the parallel user update interface.
module jtag_tap_ctrl
  import jtag_tap_ctrl_pkg::*;
#(
  parameter int               IR_W         = 4,
  parameter logic [31:0]      IDCODE       = 32'h1000_0001,
  parameter int               N_USER       = 2,
  parameter int               USER_DR_W    = 8,
  parameter logic [IR_W-1:0]  USER_IR_BASE = IR_W'(8)
) (
  input  logic                        i_tclk,
  input  logic                        i_trst,
  input  logic                        i_tms,
  input  logic                        i_tdi,
  output logic                        o_tdo,
  output logic                        o_tdoEn,
  output logic [IR_W-1:0]             o_ir,
  output logic                        o_stateIsReset,
  output logic [N_USER-1:0]           o_userSel,
  input  logic [N_USER*USER_DR_W-1:0] i_userCaptureData,
  output logic [N_USER*USER_DR_W-1:0] o_userUpdateData,
  output logic [N_USER-1:0]           o_userUpdateStrb
);

  ty_STATE_TAP_FSM state;
  logic is_reset, cap_dr, shf_dr, upd_dr, cap_ir, shf_ir, upd_ir;

  jtag_tap_fsm_sync u_fsm (
    .clk           (i_tclk),
    .rst           (i_trst),
    .tms           (i_tms),
    .state         (state),
    .is_reset      (is_reset),
    .is_capture_dr (cap_dr),
    .is_shift_dr   (shf_dr),
    .is_update_dr  (upd_dr),
    .is_capture_ir (cap_ir),
    .is_shift_ir   (shf_ir),
    .is_update_ir  (upd_ir)
  );

  logic [IR_W-1:0]      ir_q;
  logic [IR_W-1:0]      ir_shift;
  logic                 bypass_q;
  logic [IDCODE_W-1:0]  id_shift;
  logic [USER_DR_W-1:0] user_shift;
  ty_INSTR              instr;
  logic [2:0]           user_idx;

  // Test-Logic-Reset shows IDCODE immediately, not one TCK later.
  assign o_ir           = is_reset ? IR_W'(IR_OP_IDCODE) : ir_q;
  assign o_stateIsReset = is_reset;
  assign o_tdoEn        = shf_dr | shf_ir;

  always_comb begin
    instr    = INSTR_BYPASS;
    user_idx = '0;
    if (o_ir == '1) begin
      instr = INSTR_BYPASS;
    end else if (o_ir == IR_W'(IR_OP_IDCODE)) begin
      instr = INSTR_IDCODE;
    end else begin
      for (int k = 0; k < N_USER; k++) begin
        if (o_ir == USER_IR_BASE + IR_W'(k)) begin
          instr    = INSTR_USER;
          user_idx = 3'(k);
        end
      end
    end
  end

  always_comb begin
    o_userSel = '0;
    for (int k = 0; k < N_USER; k++)
      o_userSel[k] = (instr == INSTR_USER) && (user_idx == 3'(k));
  end

  always_comb begin
    o_tdo = 1'b0;
    if (shf_ir) begin
      o_tdo = ir_shift[0];
    end else if (shf_dr) begin
      case (instr)
        INSTR_IDCODE: o_tdo = id_shift[0];
        INSTR_USER:   o_tdo = user_shift[0];
        default:      o_tdo = bypass_q;
      endcase
    end
  end

  always_ff @(posedge i_tclk) begin
    if (i_trst) begin
      ir_q             <= IR_W'(IR_OP_IDCODE);
      ir_shift         <= '0;
      bypass_q         <= 1'b0;
      id_shift         <= '0;
      user_shift       <= '0;
      o_userUpdateData <= '0;
      o_userUpdateStrb <= '0;
    end else begin
      o_userUpdateStrb <= '0;

      if (is_reset) ir_q     <= IR_W'(IR_OP_IDCODE);
      if (cap_ir)   ir_shift <= IR_W'(ir_capture_pattern(IR_W));
      if (shf_ir)   ir_shift <= {i_tdi, ir_shift[IR_W-1:1]};
      if (upd_ir)   ir_q     <= ir_shift;

      if (cap_dr) begin
        case (instr)
          INSTR_IDCODE: id_shift <= IDCODE;
          INSTR_USER: begin
            for (int k = 0; k < N_USER; k++)
              if (user_idx == 3'(k))
                user_shift <= i_userCaptureData[k*USER_DR_W +: USER_DR_W];
          end
          default: bypass_q <= 1'b0;
        endcase
      end

      if (shf_dr) begin
        case (instr)
          INSTR_IDCODE: id_shift   <= {i_tdi, id_shift[IDCODE_W-1:1]};
          INSTR_USER:   user_shift <= (user_shift >> 1)
                                      | (USER_DR_W'(i_tdi) << (USER_DR_W - 1));
          default:      bypass_q   <= i_tdi;
        endcase
      end

      // Strobe lands with the data so the core can latch on the pulse alone.
      if (upd_dr && instr == INSTR_USER) begin
        for (int k = 0; k < N_USER; k++) begin
          if (user_idx == 3'(k)) begin
            o_userUpdateData[k*USER_DR_W +: USER_DR_W] <= user_shift;
            o_userUpdateStrb[k]                        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed table and sequences plus
// randomized TMS/TDI/TRST traffic against a phase/branch reference model.
module tb_jtag_tap_ctrl;

  localparam int          IR_W      = 4;
  localparam logic [31:0] IDC       = 32'h1000_0001;
  localparam int          N_USER    = 2;
  localparam int          UW        = 8;

  logic                   clk = 1'b0;
  logic                   i_trst = 1'b0, i_tms = 1'b0, i_tdi = 1'b0;
  logic                   o_tdo, o_tdoEn, o_stateIsReset;
  logic [IR_W-1:0]        o_ir;
  logic [N_USER-1:0]      o_userSel, o_userUpdateStrb;
  logic [N_USER*UW-1:0]   i_userCaptureData = '0;
  logic [N_USER*UW-1:0]   o_userUpdateData;

  jtag_tap_ctrl #(
    .IR_W(IR_W), .IDCODE(IDC), .N_USER(N_USER), .USER_DR_W(UW),
    .USER_IR_BASE(4'h8)
  ) dut (
    .i_tclk(clk), .i_trst(i_trst), .i_tms(i_tms), .i_tdi(i_tdi),
    .o_tdo(o_tdo), .o_tdoEn(o_tdoEn), .o_ir(o_ir),
    .o_stateIsReset(o_stateIsReset), .o_userSel(o_userSel),
    .i_userCaptureData(i_userCaptureData),
    .o_userUpdateData(o_userUpdateData),
    .o_userUpdateStrb(o_userUpdateStrb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a TAP position is (phase, branch) rather than a state code.
  localparam int P_TLR = 0, P_RTI = 1, P_SEL = 2, P_CAP = 3, P_SHF = 4,
                 P_EX1 = 5, P_PAU = 6, P_EX2 = 7, P_UPD = 8;
  int              m_ph = P_TLR;
  bit              m_irbr = 1'b0;
  logic [IR_W-1:0] m_ir = 4'h1, m_irsr = '0;
  logic            m_byp = 1'b0;
  logic [31:0]     m_id = '0;
  logic [UW-1:0]   m_usr = '0;
  logic [UW-1:0]   m_upd [N_USER];
  logic [N_USER-1:0] m_strb = '0;

  function automatic int m_user_k(input logic [IR_W-1:0] ir);
    if (ir == 4'hF || ir == 4'h1) return -1;
    if (int'(ir) >= 8 && int'(ir) - 8 < N_USER) return int'(ir) - 8;
    return -1;
  endfunction

  function automatic logic [IR_W-1:0] m_ir_out();
    return (m_ph == P_TLR) ? 4'h1 : m_ir;
  endfunction

  task automatic model_step(input bit trst, input bit tms, input bit tdi,
                            input logic [N_USER*UW-1:0] cap);
    logic [IR_W-1:0] ir;
    int k;
    if (trst) begin
      m_ph = P_TLR; m_irbr = 0; m_ir = 4'h1; m_irsr = '0; m_byp = 0;
      m_id = '0; m_usr = '0; m_strb = '0;
      for (int j = 0; j < N_USER; j++) m_upd[j] = '0;
      return;
    end
    ir = m_ir_out();
    k  = m_user_k(ir);
    m_strb = '0;
    if (m_ph == P_TLR) m_ir = 4'h1;
    if (m_irbr) begin
      if (m_ph == P_CAP) m_irsr = 4'b0001;
      if (m_ph == P_SHF) m_irsr = (m_irsr >> 1) | (IR_W'(tdi) << (IR_W - 1));
      if (m_ph == P_UPD) m_ir = m_irsr;
    end else if (m_ph == P_CAP) begin
      if (ir == 4'h1) m_id = IDC;
      else if (k >= 0) m_usr = cap[k*UW +: UW];
      else m_byp = 1'b0;
    end else if (m_ph == P_SHF) begin
      if (ir == 4'h1) m_id = (m_id >> 1) | (32'(tdi) << 31);
      else if (k >= 0) m_usr = (m_usr >> 1) | (UW'(tdi) << (UW - 1));
      else m_byp = tdi;
    end else if (m_ph == P_UPD && k >= 0) begin
      m_upd[k] = m_usr;
      m_strb[k] = 1'b1;
    end
    case (m_ph)
      P_TLR: m_ph = tms ? P_TLR : P_RTI;
      P_RTI: begin m_ph = tms ? P_SEL : P_RTI; m_irbr = 0; end
      P_SEL: if (!m_irbr) begin
               if (tms) m_irbr = 1; else m_ph = P_CAP;
             end else m_ph = tms ? P_TLR : P_CAP;
      P_CAP, P_SHF: m_ph = tms ? P_EX1 : P_SHF;
      P_EX1: m_ph = tms ? P_UPD : P_PAU;
      P_PAU: m_ph = tms ? P_EX2 : P_PAU;
      P_EX2: m_ph = tms ? P_UPD : P_SHF;
      default: begin m_ph = tms ? P_SEL : P_RTI; m_irbr = 0; end
    endcase
    if (m_ph == P_TLR) m_irbr = 0;
  endtask

  function automatic logic [63:0] model_outs();
    logic [IR_W-1:0] ir;
    logic tdo;
    logic [N_USER-1:0] sel;
    int k;
    ir = m_ir_out();
    k  = m_user_k(ir);
    sel = '0;
    if (k >= 0) sel[k] = 1'b1;
    tdo = 1'b0;
    if (m_ph == P_SHF) begin
      if (m_irbr) tdo = m_irsr[0];
      else if (ir == 4'h1) tdo = m_id[0];
      else if (k >= 0) tdo = m_usr[0];
      else tdo = m_byp;
    end
    return 64'({tdo, m_ph == P_SHF, ir, m_ph == P_TLR, sel, m_upd[1], m_upd[0], m_strb});
  endfunction

  function automatic logic [63:0] dut_outs();
    return 64'({o_tdo, o_tdoEn, o_ir, o_stateIsReset, o_userSel,
                o_userUpdateData, o_userUpdateStrb});
  endfunction

  // Inputs change just after a negedge; outputs are compared at the next negedge.
  task automatic tick(input bit trst, input bit tms, input bit tdi);
    i_trst = trst; i_tms = tms; i_tdi = tdi;
    @(posedge clk);
    model_step(trst, tms, tdi, i_userCaptureData);
    @(negedge clk);
    check("cycle", dut_outs(), model_outs());
  endtask

  // From Run-Test/Idle: load an IR value, return the bits seen on TDO.
  task automatic load_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] seen);
    tick(0, 1, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < IR_W; i++) begin
      seen[i] = o_tdo;
      tick(0, i == IR_W - 1, val[i]);
    end
    tick(0, 1, 0); tick(0, 0, 0);
  endtask

  // From Run-Test/Idle: shift n DR bits, update, return to Idle.
  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = o_tdo;
      tick(0, i == n - 1, din[i]);
    end
    tick(0, 1, 0); tick(0, 0, 0);
  endtask

  typedef struct {
    bit tms; bit tdi; bit exp_tdo; bit exp_en; logic [1:0] exp_strb;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [IR_W-1:0] seen;
    logic [31:0]     dout;
    logic [31:0]     idc_v;

    for (int j = 0; j < N_USER; j++) m_upd[j] = '0;
    tbl[0] = '{1, 0, 0, 0, 2'b00};
    tbl[1] = '{0, 0, 0, 0, 2'b00};
    tbl[2] = '{0, 0, 0, 1, 2'b00};
    tbl[3] = '{0, 1, 1, 1, 2'b00};
    tbl[4] = '{0, 0, 0, 1, 2'b00};
    tbl[5] = '{0, 1, 1, 1, 2'b00};
    tbl[6] = '{1, 1, 0, 0, 2'b00};
    tbl[7] = '{1, 0, 0, 0, 2'b00};
    tbl[8] = '{0, 0, 0, 0, 2'b00};

    // Reset, then read IDCODE LSB first.
    tick(1, 0, 0);
    check("rst_state", 64'({o_stateIsReset, o_ir, o_tdoEn, o_tdo}), 64'({1'b1, 4'h1, 1'b0, 1'b0}));
    check("rst_user", 64'({o_userUpdateData, o_userUpdateStrb}), 64'h0);
    tick(0, 0, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    idc_v = IDC;
    dout = '0;
    for (int i = 0; i < 32; i++) begin
      dout[i] = o_tdo;
      if (!o_tdoEn) check("idcode_en", 64'(o_tdoEn), 64'h1);
      tick(0, i == 31, 0);
    end
    check("idcode_read", 64'(dout), 64'(idc_v));
    tick(0, 1, 0); tick(0, 0, 0);

    // BYPASS via all-ones IR, then the one-bit delay table.
    load_ir(4'hF, seen);
    check("ir_capture", 64'(seen), 64'h1);
    check("ir_bypass", 64'({o_ir, o_userSel}), 64'({4'hF, 2'b00}));
    for (int i = 0; i < 9; i++) begin
      tick(0, tbl[i].tms, tbl[i].tdi);
      check($sformatf("tbl%0d", i), 64'({o_tdo, o_tdoEn, o_userUpdateStrb}),
            64'({tbl[i].exp_tdo, tbl[i].exp_en, tbl[i].exp_strb}));
    end

    // USER1 capture/update with strobe.
    i_userCaptureData = {8'hA5, 8'h5A};
    load_ir(4'h9, seen);
    check("user1_sel", 64'(o_userSel), 64'h2);
    shift_dr(32'h3C, 8, dout);
    check("user1_read", 64'(dout), 64'hA5);
    check("user1_upd", 64'({o_userUpdateData[15:8], o_userUpdateStrb}), 64'({8'h3C, 2'b10}));
    tick(0, 0, 0);
    check("user1_strb_end", 64'({o_userUpdateData[15:8], o_userUpdateStrb}), 64'({8'h3C, 2'b00}));

    // USER0 capture/update.
    load_ir(4'h8, seen);
    shift_dr(32'h96, 8, dout);
    check("user0_read", 64'(dout), 64'h5A);
    check("user0_upd", 64'({o_userUpdateData, o_userUpdateStrb}), 64'({16'h3C96, 2'b01}));

    // Five TMS=1 from Shift-IR reach reset; user data survives.
    tick(0, 1, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    check("shir_en", 64'(o_tdoEn), 64'h1);
    for (int i = 0; i < 5; i++) tick(0, 1, 0);
    check("tms_reset", 64'({o_stateIsReset, o_ir}), 64'({1'b1, 4'h1}));
    check("tms_reset_keep", 64'(o_userUpdateData), 64'h3C96);
    tick(0, 0, 0);

    // Undefined opcode acts as BYPASS with no update.
    load_ir(4'h5, seen);
    check("undef_sel", 64'(o_userSel), 64'h0);
    shift_dr(32'hFF, 8, dout);
    check("undef_read", 64'(dout), 64'hFE);
    check("undef_noupd", 64'({o_userUpdateData, o_userUpdateStrb}), 64'({16'h3C96, 2'b00}));

    // TRST mid Shift-DR of USER0 aborts the shift.
    load_ir(4'h8, seen);
    tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 0, 1); tick(0, 0, 1); tick(0, 0, 1);
    tick(1, 0, 1);
    check("trst_state", 64'({o_stateIsReset, o_ir, o_tdoEn, o_tdo}), 64'({1'b1, 4'h1, 1'b0, 1'b0}));
    check("trst_user", 64'({o_userUpdateData, o_userUpdateStrb}), 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      i_userCaptureData = 16'($urandom);
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 35, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
